// File: rtl/measure_seq.sv
// Sequential argmax measurement over a snapshotted amplitude vector.
// Scans one element per cycle and reports the winning index and score.
module measure_seq #(
    parameter int NSTATES = 4,
    parameter int W = 8,
    localparam int IDX_W = $clog2(NSTATES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [NSTATES*W-1:0] state_real_flat,
    output logic                 busy,
    output logic                 valid,
    output logic [IDX_W-1:0]     measured_result,
    output logic [W-1:0]         max_mag,
    output logic                 none
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSTATES - 1);

    state_t               state;
    logic [NSTATES*W-1:0] snap;
    logic                 snap_mode;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     best_idx;
    logic [W-1:0]         run_max;
    logic [W-1:0]         elem;
    logic [W-1:0]         score;
    logic                 qual;

    // Negating the most negative value wraps to 2^(W-1), its unsigned magnitude.
    always_comb begin
        elem  = snap[int'(idx)*W +: W];
        score = (snap_mode && elem[W-1]) ? -elem : elem;
        qual  = (snap_mode || !elem[W-1]) && (score > run_max);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            snap            <= '0;
            snap_mode       <= 1'b0;
            idx             <= '0;
            best_idx        <= '0;
            run_max         <= '0;
            busy            <= 1'b0;
            valid           <= 1'b0;
            measured_result <= '0;
            max_mag         <= '0;
            none            <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start && !busy) begin
                        state     <= SCAN;
                        snap      <= state_real_flat;
                        snap_mode <= mode;
                        idx       <= '0;
                        best_idx  <= '0;
                        run_max   <= '0;
                    end
                end
                SCAN: begin
                    busy <= 1'b1;
                    if (qual) begin
                        run_max  <= score;
                        best_idx <= idx;
                    end
                    if (idx == LAST) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    busy            <= 1'b1;
                    valid           <= 1'b1;
                    measured_result <= best_idx;
                    max_mag         <= run_max;
                    none            <= (run_max == '0);
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_measure_seq.sv
// Bench for measure_seq: directed table on a 4x8 instance,
// random vectors against an argmax model on an 8x12 instance.
module tb_measure_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;
    always @(posedge clk) edges++;

    logic        rst4, start4, mode4, busy4, valid4, none4;
    logic [31:0] flat4;
    logic [1:0]  res4;
    logic [7:0]  mag4;

    logic        rst8, start8, mode8, busy8, valid8, none8;
    logic [95:0] flat8;
    logic [2:0]  res8;
    logic [11:0] mag8;

    measure_seq #(.NSTATES(4), .W(8)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .mode(mode4),
        .state_real_flat(flat4), .busy(busy4), .valid(valid4),
        .measured_result(res4), .max_mag(mag4), .none(none4)
    );

    measure_seq #(.NSTATES(8), .W(12)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .mode(mode8),
        .state_real_flat(flat8), .busy(busy8), .valid(valid8),
        .measured_result(res8), .max_mag(mag8), .none(none8)
    );

    typedef struct {
        logic [31:0] flat;
        logic        mode;
        int          res;
        int          mag;
        int          none;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for a valid pulse on the selected instance.
    task automatic wait_valid(input bit big, output int at, output bit to);
        to = 1'b1;
        at = -1;
        for (int i = 0; i < 30; i++) begin
            if (big ? valid8 : valid4) begin
                to = 1'b0;
                at = edges;
                break;
            end
            @(negedge clk);
        end
        if (to) chk("valid_timeout", 1, 0);
    endtask

    task automatic run4(input logic [31:0] f, input logic m, output int lat, output bit to);
        int e0, at;
        @(negedge clk);
        start4 = 1'b1;
        flat4  = f;
        mode4  = m;
        e0     = edges;
        @(negedge clk);
        start4 = 1'b0;
        flat4  = ~f;
        mode4  = ~m;
        chk("busy_low_after_e0", busy4, 0);
        wait_valid(1'b0, at, to);
        lat = at - e0 - 1;
    endtask

    task automatic run8(input logic [95:0] f, input logic m, output int lat, output bit to);
        int e0, at;
        @(negedge clk);
        start8 = 1'b1;
        flat8  = f;
        mode8  = m;
        e0     = edges;
        @(negedge clk);
        start8 = 1'b0;
        flat8  = ~f;
        mode8  = ~m;
        wait_valid(1'b1, at, to);
        lat = at - e0 - 1;
    endtask

    function automatic void model8(input logic [95:0] f, input logic m,
                                   output int bi, output int best);
        int v, s;
        best = 0;
        bi   = 0;
        for (int i = 0; i < 8; i++) begin
            v = int'($signed(f[i*12 +: 12]));
            if (m) s = (v < 0) ? -v : v;
            else   s = (v > 0) ? v : 0;
            if (s > best) begin
                best = s;
                bi   = i;
            end
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat, v1, v2, cnt, bi, best;
        bit  to;
        logic [95:0] f8;
        logic        m8;

        tbl[0] = '{32'h107F0520, 1'b0, 2, 8'h7F, 0};
        tbl[1] = '{32'h30303030, 1'b0, 0, 8'h30, 0};
        tbl[2] = '{32'h80FF9CA0, 1'b0, 0, 8'h00, 1};
        tbl[3] = '{32'h80FF9CA0, 1'b1, 3, 8'h80, 0};
        tbl[4] = '{32'h7F807F01, 1'b0, 1, 8'h7F, 0};
        tbl[5] = '{32'h7F807F01, 1'b1, 2, 8'h80, 0};
        tbl[6] = '{32'h00000000, 1'b1, 0, 8'h00, 1};
        tbl[7] = '{32'h01000000, 1'b0, 3, 8'h01, 0};

        rst4 = 1'b1; start4 = 1'b0; mode4 = 1'b0; flat4 = '0;
        rst8 = 1'b1; start8 = 1'b0; mode8 = 1'b0; flat8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy4, 0);
        chk("rst_valid", valid4, 0);
        chk("rst_res", res4, 0);
        chk("rst_mag", mag4, 0);
        chk("rst_none", none4, 0);
        rst4 = 1'b0;
        rst8 = 1'b0;

        for (int k = 0; k < 8; k++) begin
            run4(tbl[k].flat, tbl[k].mode, lat, to);
            chk($sformatf("v%0d_latency", k), lat, 5);
            chk($sformatf("v%0d_busy_valid", k), busy4, 1);
            chk($sformatf("v%0d_res", k), res4, tbl[k].res);
            chk($sformatf("v%0d_mag", k), mag4, tbl[k].mag);
            chk($sformatf("v%0d_none", k), none4, tbl[k].none);
            @(negedge clk);
            chk($sformatf("v%0d_pulse_end", k), valid4, 0);
            chk($sformatf("v%0d_idle", k), busy4, 0);
            chk($sformatf("v%0d_hold_mag", k), mag4, tbl[k].mag);
        end

        // start held high; vector changes right after acceptance
        @(negedge clk);
        start4 = 1'b1;
        mode4  = 1'b0;
        flat4  = 32'h107F0520;
        @(negedge clk);
        flat4  = 32'h30303030;
        wait_valid(1'b0, v1, to);
        chk("hold1_res", res4, 2);
        chk("hold1_mag", mag4, 8'h7F);
        @(negedge clk);
        wait_valid(1'b0, v2, to);
        chk("hold2_res", res4, 0);
        chk("hold2_mag", mag4, 8'h30);
        chk("hold_period_min", (v2 - v1) >= 6, 1);
        start4 = 1'b0;
        repeat (8) @(negedge clk);

        // reset during the second SCAN cycle
        start4 = 1'b1;
        flat4  = 32'h107F0520;
        mode4  = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        #1;
        chk("midrst_busy", busy4, 0);
        chk("midrst_mag", mag4, 0);
        @(negedge clk);
        rst4 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid4) cnt++;
            @(negedge clk);
        end
        chk("midrst_no_valid", cnt, 0);
        chk("midrst_res", res4, 0);
        chk("midrst_none", none4, 0);
        chk("midrst_busy_after", busy4, 0);
        run4(32'h107F0520, 1'b0, lat, to);
        chk("postrst_latency", lat, 5);
        chk("postrst_res", res4, 2);
        chk("postrst_mag", mag4, 8'h7F);
        @(negedge clk);

        for (int r = 0; r < 1000; r++) begin
            f8 = {$urandom, $urandom, $urandom};
            m8 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                f8[$urandom_range(0, 7)*12 +: 12] = 12'h800;
            if ($urandom_range(0, 3) == 0)
                f8[$urandom_range(0, 7)*12 +: 12] = f8[$urandom_range(0, 7)*12 +: 12];
            if ($urandom_range(0, 7) == 0)
                f8 = f8 | {8{12'h800}};
            model8(f8, m8, bi, best);
            run8(f8, m8, lat, to);
            chk($sformatf("r%0d_latency", r), lat, 9);
            chk($sformatf("r%0d_res", r), res8, bi);
            chk($sformatf("r%0d_mag", r), mag8, best);
            chk($sformatf("r%0d_none", r), none8, (best == 0) ? 1 : 0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
